// File: rtl/cdb_issue_sched_pkg.sv
// Shared constants for the CDB issue scheduler: result latencies, booking depth, owner codes.
package cobalt_issue_pkg;

  localparam int RESV_DEPTH = 8;
  localparam int MUL_LAT    = 4;
  localparam int DIV_LAT    = 7;
  localparam int DIV_CNT_W  = 3;

  typedef enum logic [1:0] {
    SRC_INT  = 2'd0,
    SRC_LDST = 2'd1,
    SRC_MUL  = 2'd2,
    SRC_DIV  = 2'd3
  } src_e;

endpackage

// File: rtl/cdb_issue_sched_arb.sv
// Two-way int/ldst arbiter for the single slot-1 CDB booking.
// ISSUE_RR_EN selects round-robin (rr_last state); otherwise fixed int-over-ldst priority.
module issue_rr_arb (
`ifdef ISSUE_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic req_int,
  input  logic req_ldst,
  output logic gnt_int,
  output logic gnt_ldst
);

`ifdef ISSUE_RR_EN
  // rr_last: 0 = int won last, 1 = ldst won last; the other side wins a tie
  logic rr_last;

  always_comb begin
    gnt_int  = 1'b0;
    gnt_ldst = 1'b0;
    if (en) begin
      if (req_int && req_ldst) begin
        gnt_int  = rr_last;
        gnt_ldst = !rr_last;
      end else begin
        gnt_int  = req_int;
        gnt_ldst = req_ldst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b0;
    end else if (gnt_int || gnt_ldst) begin
      rr_last <= gnt_ldst;
    end
  end
`else
  assign gnt_int  = en && req_int;
  assign gnt_ldst = en && req_ldst && !req_int;
`endif

endmodule

// File: rtl/cdb_issue_sched.sv
// Issue scheduler that books common-data-bus slots ahead of time for int/ldst/mul/div units.
// Optional macro ISSUE_RR_EN: round-robin int vs ldst tie-break instead of fixed int priority.
module cdb_issue_sched
  import cobalt_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       int_ready,
  input  logic       ldst_ready,
  input  logic       mul_ready,
  input  logic       div_ready,
  output logic       issue_int,
  output logic       issue_ldst,
  output logic       issue_mul,
  output logic       issue_div,
  output logic       cdb_src_valid,
  output logic [1:0] cdb_src,
  output logic       div_busy
);

  // resv[k]: CDB booked k cycles from now; own[k] is the owner of that booking.
  // Unbooked slots always hold owner 0, so own[0] reads 0 whenever the bus is idle.
  logic [RESV_DEPTH-1:0] resv;
  logic [RESV_DEPTH-1:0] resv_nxt;
  logic [1:0]            own     [RESV_DEPTH];
  logic [1:0]            own_nxt [RESV_DEPTH];
  logic [DIV_CNT_W-1:0]  div_cnt;
  logic                  lo_slot_free;

  assign lo_slot_free = !rst && !resv[1];
  assign issue_mul    = !rst && mul_ready && !resv[MUL_LAT];
  assign issue_div    = !rst && div_ready && !resv[DIV_LAT] && (div_cnt == '0);

  issue_rr_arb u_arb (
`ifdef ISSUE_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .en       (lo_slot_free),
    .req_int  (int_ready),
    .req_ldst (ldst_ready),
    .gnt_int  (issue_int),
    .gnt_ldst (issue_ldst)
  );

  // Next booking table: age every slot by one, then drop the new grants into their target slots
  always_comb begin
    resv_nxt = resv >> 1;
    for (int k = 0; k < RESV_DEPTH - 1; k++) begin
      own_nxt[k] = own[k+1];
    end
    own_nxt[RESV_DEPTH-1] = SRC_INT;
    if (issue_div) begin
      resv_nxt[DIV_LAT-1] = 1'b1;
      own_nxt[DIV_LAT-1]  = SRC_DIV;
    end
    if (issue_mul) begin
      resv_nxt[MUL_LAT-1] = 1'b1;
      own_nxt[MUL_LAT-1]  = SRC_MUL;
    end
    if (issue_int) begin
      resv_nxt[0] = 1'b1;
      own_nxt[0]  = SRC_INT;
    end
    if (issue_ldst) begin
      resv_nxt[0] = 1'b1;
      own_nxt[0]  = SRC_LDST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv    <= '0;
      own     <= '{default: '0};
      div_cnt <= '0;
    end else begin
      resv <= resv_nxt;
      own  <= own_nxt;
      if (issue_div) begin
        div_cnt <= DIV_CNT_W'(DIV_LAT - 1);
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - DIV_CNT_W'(1);
      end
    end
  end

  assign cdb_src_valid = resv[0];
  assign cdb_src       = own[0];
  assign div_busy      = (div_cnt != '0);

endmodule

// File: tb/tb_cdb_issue_sched.sv
// Bench for cdb_issue_sched: absolute-time booking model checked every cycle plus directed scenarios.
module tb_cdb_issue_sched;

  localparam int LO_LAT = 1;
  localparam int MUL_L  = 4;
  localparam int DIV_L  = 7;
  localparam int TL     = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_ready = 1'b0, ldst_ready = 1'b0, mul_ready = 1'b0, div_ready = 1'b0;
  logic       issue_int, issue_ldst, issue_mul, issue_div;
  logic       cdb_src_valid, div_busy;
  logic [1:0] cdb_src;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cdb_issue_sched dut (
    .clk           (clk),
    .rst           (rst),
    .int_ready     (int_ready),
    .ldst_ready    (ldst_ready),
    .mul_ready     (mul_ready),
    .div_ready     (div_ready),
    .issue_int     (issue_int),
    .issue_ldst    (issue_ldst),
    .issue_mul     (issue_mul),
    .issue_div     (issue_div),
    .cdb_src_valid (cdb_src_valid),
    .cdb_src       (cdb_src),
    .div_busy      (div_busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: bus occupancy on an absolute cycle timeline, divider free-at time, last int/ldst winner
  bit       bk  [TL];
  bit [1:0] bo  [TL];
  bit       dbk [TL];
  int       cyc      = 0;
  int       div_free = 0;
  bit       ldst_won = 1'b0;

  always @(negedge clk) begin : compare
    bit e_int, e_ldst, e_mul, e_div;
    e_int = 1'b0; e_ldst = 1'b0; e_mul = 1'b0; e_div = 1'b0;
    if (cyc < TL - 16) begin
      if (!rst) begin
        if (!bk[cyc+LO_LAT]) begin
          if (int_ready && ldst_ready) begin
`ifdef ISSUE_RR_EN
            e_int  = ldst_won;
            e_ldst = !ldst_won;
`else
            e_int  = 1'b1;
`endif
          end else begin
            e_int  = int_ready;
            e_ldst = ldst_ready;
          end
        end
        e_mul = mul_ready && !bk[cyc+MUL_L];
        e_div = div_ready && !bk[cyc+DIV_L] && (cyc >= div_free);
      end
      chk1("issue_int", issue_int, e_int);
      chk1("issue_ldst", issue_ldst, e_ldst);
      chk1("issue_mul", issue_mul, e_mul);
      chk1("issue_div", issue_div, e_div);
      chk1("cdb_src_valid", cdb_src_valid, bk[cyc]);
      chk2("cdb_src", cdb_src, bk[cyc] ? bo[cyc] : 2'd0);
      chk1("div_busy", div_busy, cyc < div_free);
      // Bus-slot collisions judged from the DUT's own grants
      if (issue_int === 1'b1 || issue_ldst === 1'b1) begin
        chk1("no_double_book_lo", dbk[cyc+LO_LAT], 1'b0);
        dbk[cyc+LO_LAT] = 1'b1;
      end
      if (issue_mul === 1'b1) begin
        chk1("no_double_book_mul", dbk[cyc+MUL_L], 1'b0);
        dbk[cyc+MUL_L] = 1'b1;
      end
      if (issue_div === 1'b1) begin
        chk1("no_double_book_div", dbk[cyc+DIV_L], 1'b0);
        dbk[cyc+DIV_L] = 1'b1;
      end
      if (rst) begin
        for (int k = 1; k <= 8; k++) begin
          bk[cyc+k]  = 1'b0;
          dbk[cyc+k] = 1'b0;
        end
        div_free = 0;
        ldst_won = 1'b0;
      end else begin
        if (e_int || e_ldst) begin
          bk[cyc+LO_LAT] = 1'b1;
          bo[cyc+LO_LAT] = e_int ? 2'd0 : 2'd1;
          ldst_won       = e_ldst;
        end
        if (e_mul) begin
          bk[cyc+MUL_L] = 1'b1;
          bo[cyc+MUL_L] = 2'd2;
        end
        if (e_div) begin
          bk[cyc+DIV_L] = 1'b1;
          bo[cyc+DIV_L] = 2'd3;
          div_free      = cyc + DIV_L;
        end
      end
    end
    cyc++;
  end

  // v = {rst, int_ready, ldst_ready, mul_ready, div_ready}; returns at mid-first-half of the cycle
  task automatic step(input logic [4:0] v);
    @(posedge clk);
    #1;
    {rst, int_ready, ldst_ready, mul_ready, div_ready} = v;
    #3;
  endtask

  task automatic rst_seq();
    step(5'b11111);
    step(5'b11111);
    chk1("rst_valid", cdb_src_valid, 1'b0);
    chk2("rst_src", cdb_src, 2'd0);
    chk1("rst_busy", div_busy, 1'b0);
    chk1("rst_no_int", issue_int, 1'b0);
    chk1("rst_no_ldst", issue_ldst, 1'b0);
    chk1("rst_no_mul", issue_mul, 1'b0);
    chk1("rst_no_div", issue_div, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(5'b00000);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] s3_int;
    s3_int = 8'b1011_0111;

    // Single int issue: result on the bus one cycle later
    rst_seq();
    step(5'b01000);
    chk1("s1_issue_int_c0", issue_int, 1'b1);
    step(5'b00000);
    chk1("s1_valid_c1", cdb_src_valid, 1'b1);
    chk2("s1_src_c1", cdb_src, 2'd0);
    drain(6);

    // Divider occupancy and a blocked second divide
    rst_seq();
    for (int c = 0; c < 8; c++) begin
      step({4'b0000, (c == 0) || (c >= 3)});
      if (c == 0) chk1("s2_div_c0", issue_div, 1'b1);
      if (c >= 1 && c <= 6) chk1("s2_busy", div_busy, 1'b1);
      if (c >= 3 && c <= 6) chk1("s2_div_blocked", issue_div, 1'b0);
      if (c == 7) begin
        chk1("s2_div_c7", issue_div, 1'b1);
        chk1("s2_busy_c7", div_busy, 1'b0);
        chk1("s2_valid_c7", cdb_src_valid, 1'b1);
        chk2("s2_src_c7", cdb_src, 2'd3);
      end
    end
    drain(12);

    // mul + div at cycle 0 steal slot 1 from int at cycles 3 and 6
    rst_seq();
    for (int c = 0; c < 8; c++) begin
      step({3'b010, c == 0, c == 0});
      chk1("s3_int_pattern", issue_int, s3_int[c]);
      if (c == 0) begin
        chk1("s3_mul_c0", issue_mul, 1'b1);
        chk1("s3_div_c0", issue_div, 1'b1);
      end
      if (c == 4) chk2("s3_src_c4", cdb_src, 2'd2);
      if (c == 7) chk2("s3_src_c7", cdb_src, 2'd3);
    end
    drain(10);

    // int vs ldst contention
    rst_seq();
    for (int c = 0; c < 4; c++) begin
      step(5'b01100);
`ifdef ISSUE_RR_EN
      chk1("s4_int", issue_int, c[0]);
      chk1("s4_ldst", issue_ldst, !c[0]);
`else
      chk1("s4_int", issue_int, 1'b1);
      chk1("s4_ldst", issue_ldst, 1'b0);
`endif
    end
    drain(4);

    // Reset in the middle of mul bookings discards them
    rst_seq();
    step(5'b00010);
    step(5'b00010);
    step(5'b10010);
    chk1("s5_no_mul_in_rst", issue_mul, 1'b0);
    for (int c = 3; c < 9; c++) begin
      step(5'b00000);
      chk1("s5_valid_cleared", cdb_src_valid, 1'b0);
    end
    drain(2);

    // Everything ready for 20 cycles
    rst_seq();
    for (int c = 0; c < 20; c++) begin
      step(5'b01111);
      chk1("s6_div_grant", issue_div, (c == 0) || (c == 7) || (c == 14));
    end
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cdb_issue_sched.md
CDB_ISSUE_SCHED -- requirements
Module: cdb_issue_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: int_ready, ldst_ready, mul_ready, div_ready  input  1 each  queue has an issuable instruction.
REQ-004 SHALL have ports: issue_int, issue_ldst, issue_mul, issue_div  output  1 each  grant, combinational, same cycle as ready.
REQ-005 SHALL have port: cdb_src_valid  output  1  the CDB carries a result this cycle (registered).
REQ-006 SHALL have port: cdb_src  output  2  owner of the current CDB cycle: 0 int, 1 ldst, 2 mul, 3 div (registered).
REQ-007 SHALL have port: div_busy  output  1  the divider is occupied (registered).

Function
REQ-008 SHALL keep resv[7:0]; resv[k]=1 means the CDB is booked k cycles from now.
REQ-009 SHALL keep own[7:0][1:0] holding the owner code of each booked slot.
REQ-010 SHALL use issue-to-CDB latencies: int/ldst 1, mul MUL_LAT=4, div DIV_LAT=7.
REQ-011 SHALL grant issue_div iff div_ready & !resv[DIV_LAT] & div_cnt==0.
REQ-012 SHALL grant issue_mul iff mul_ready & !resv[MUL_LAT]; the multiplier is fully pipelined.
REQ-013 SHALL grant at most one of issue_int/issue_ldst, and only when !resv[1].
REQ-014 SHALL allow div, mul and one of int/ldst to be granted in the same cycle, because their target slots differ.
REQ-015 SHALL update each posedge: resv <= (resv>>1) | issue_div<<(DIV_LAT-1) | issue_mul<<(MUL_LAT-1) | (issue_int|issue_ldst)<<0; own shifts identically and loads the granted code.
REQ-016 SHALL drive cdb_src_valid=resv[0] and cdb_src=own[0].
REQ-017 SHALL hold cdb_src at 0 while resv[0]=0.
REQ-018 SHALL load div_cnt (3 bits) with DIV_LAT-1 on issue_div and otherwise decrement it to 0 with saturation.
REQ-019 SHALL drive div_busy = (div_cnt!=0).
REQ-020 SHALL never book a slot twice; the bench asserts that a shift-in never lands on a set bit.
REQ-021 SHALL never assert a grant without the matching ready.
REQ-022 SHALL let int and ldst contend for slot 1 when it is free, resolved per REQ-027/REQ-028.
REQ-023 SHALL leave slot 1 free (int/ldst stall) when resv[1] is set by an earlier mul or div booking.

Reset
REQ-024 SHALL clear resv, own, div_cnt and rr_last on rst (synchronous); cdb_src_valid=0, cdb_src=0, div_busy=0.
REQ-025 SHALL force all issue_* outputs to 0 while rst is high.
REQ-026 SHALL discard all bookings when rst is asserted mid-operation, with the first grants possible in the cycle after rst deasserts.

Configuration
REQ-027 SHALL, with ISSUE_RR_EN defined, use a round-robin 1-bit rr_last (0=int last, reset 0) for int vs ldst: the non-last requester wins a tie, so ldst wins the first tie after reset; rr_last updates only on an int/ldst grant.
REQ-028 SHALL, without ISSUE_RR_EN, use fixed priority int over ldst and remove rr_last.

Structure
REQ-029 SHALL place MUL_LAT, DIV_LAT, RESV_DEPTH=8 and the owner codes (SRC_INT..SRC_DIV) in the shared package cobalt_issue_pkg.
REQ-030 SHALL implement the int/ldst tie-break in one sub-module, issue_rr_arb (2-way arbiter, RR or fixed per macro); all other logic is flat.

Verification
REQ-031 SHALL cover: after reset, int_ready=1 only at cycle 0 -> issue_int=1 at cycle 0; cdb_src_valid=1, cdb_src=0 at cycle 1.
REQ-032 SHALL cover: div_ready=1 at cycle 0 -> issue_div=1; div_busy=1 for cycles 1-6; cdb_src=3 at cycle 7; a second div_ready at cycle 3 is not granted until cycle 7.
REQ-033 SHALL cover: mul issued at cycle 0 and div issued at cycle 0, int_ready held from cycle 0 -> int granted at cycles 0-2, 4, 5, 7, but not at 3 or 6 (resv[1] set by the mul and div bookings).
REQ-034 SHALL cover: int_ready=ldst_ready=1 for 4 cycles -> with ISSUE_RR_EN grants are ldst, int, ldst, int; without it, int x4.
REQ-035 SHALL cover: mul issued at cycles 0, 1, 2 with rst=1 at cycle 2 -> no grant at cycle 2, cdb_src_valid=0 from cycle 3 onward, resv=0.
REQ-036 SHALL cover: all four queues ready every cycle for 20 cycles -> no double booking, div grants at cycles 0, 7, 14, and cdb_src_valid matches resv[0] every cycle.
